// File: rtl/xor_frame_accum_if.sv
// Frame-accumulator handshake bundle: XOR word input stream and frame result output.
// The master modport is the upstream producer plus the result sink; slave is the accumulator.
interface xor_frame_accum_if #(
  parameter int N       = 4,
  parameter int MAX_LEN = 8
);
  localparam int CW = $clog2(MAX_LEN + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic [CW-1:0] out_len;
  logic          out_zero;
  logic          out_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_zero, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_zero, out_trunc
  );
endinterface

// File: rtl/xor_frame_accum.sv
// Folds one frame of XOR words into a running checksum and word count, then holds
// the result on a valid/ready port; frames close on in_last or after MAX_LEN words.
module xor_frame_accum #(
  parameter int N       = 4,
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rstn,
  xor_frame_accum_if.slave   bus
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ready_q;
  logic          valid_q;
  logic          zero_q;
  logic          trunc_q;

  logic          beat;
  logic          close;
  logic [N-1:0]  acc_nxt;
  logic [CW-1:0] cnt_nxt;

  // ready_q is low during reset and in HOLD, so a beat can never land in HOLD.
  assign beat = bus.in_valid && ready_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    acc_nxt = acc ^ bus.in_data;
    cnt_nxt = cnt + CW'(1);
    if (state == IDLE) begin
      acc_nxt = bus.in_data;
      cnt_nxt = CW'(1);
    end
    // in_last takes priority, so trunc is only set when the count alone closes the frame.
    close = bus.in_last || (cnt_nxt == CW'(MAX_LEN));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE, ACC: begin
          ready_q <= 1'b1;
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (close) begin
              state   <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              zero_q  <= (acc_nxt == '0);
              trunc_q <= !bus.in_last;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            trunc_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_len   = cnt;
  assign bus.out_zero  = zero_q;
  assign bus.out_trunc = trunc_q;
endmodule

// File: tb/tb_xor_frame_accum.sv
// Directed and randomized frames for xor_frame_accum, checked against a queue-based
// frame model that XORs and counts the accepted words of each frame.
module tb_xor_frame_accum;
  localparam int N       = 4;
  localparam int MAX_LEN = 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  xor_frame_accum_if #(.N(N), .MAX_LEN(MAX_LEN)) bus ();

  xor_frame_accum #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words of the open frame, and the expected result of the closed one.
  logic [N-1:0] frame_q[$];
  logic         pending   = 1'b0;
  logic [N-1:0] exp_sum   = '0;
  int           exp_len   = 0;
  logic         exp_trunc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [N-1:0] d, input logic l);
    frame_q.push_back(d);
    if (l || frame_q.size() == MAX_LEN) begin
      exp_sum = '0;
      foreach (frame_q[i]) exp_sum ^= frame_q[i];
      exp_len   = frame_q.size();
      exp_trunc = !l;
      pending   = 1'b1;
      frame_q.delete();
    end
  endtask

  // Offer one word from a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [N-1:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(negedge clk);
      model_accept(d, l);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_pending"}, 32'(pending), 32'd1);
    check({tag, "_valid"},   32'(bus.out_valid), 32'd1);
    check({tag, "_sum"},     32'(bus.out_sum), 32'(exp_sum));
    check({tag, "_len"},     32'(bus.out_len), 32'(exp_len));
    check({tag, "_zero"},    32'(bus.out_zero), 32'(exp_sum == '0));
    check({tag, "_trunc"},   32'(bus.out_trunc), 32'(exp_trunc));
    check({tag, "_ready"},   32'(bus.in_ready), 32'd0);
  endtask

  // Keep out_ready low for 'stall' cycles checking stability, then drain.
  task automatic drain(input string tag, input int stall);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_sum"},   32'(bus.out_sum), 32'(exp_sum));
      check({tag, "_hold_len"},   32'(bus.out_len), 32'(exp_len));
      check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    pending = 1'b0;
    check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_drain_sum"},   32'(bus.out_sum), 32'd0);
    check({tag, "_drain_len"},   32'(bus.out_len), 32'd0);
    check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rstn          = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",   32'(bus.out_sum), 32'd0);
    check("rst_len",   32'(bus.out_len), 32'd0);
    check("rst_zero",  32'(bus.out_zero), 32'd0);
    check("rst_trunc", 32'(bus.out_trunc), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // 1: 3^5^6 = 0, back-to-back
    send(4'h3, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b1);
    check("t1_sum_const", 32'(bus.out_sum), 32'h0);
    check("t1_zero_const", 32'(bus.out_zero), 32'd1);
    check_frame("t1");
    drain("t1", 0);

    // 2: single-word frame
    send(4'hA, 1'b1);
    check("t2_len_const", 32'(bus.out_len), 32'd1);
    check_frame("t2");
    drain("t2", 1);

    // 3: MAX_LEN words without last -> truncated; 9th word held off until drained
    for (int i = 0; i < MAX_LEN; i++) send(4'h1, 1'b0);
    check("t3_trunc_const", 32'(bus.out_trunc), 32'd1);
    check_frame("t3");
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h1;
    bus.in_last  = 1'b1;
    drain("t3", 2);
    send(4'h1, 1'b1);
    check_frame("t3b");
    drain("t3b", 0);

    // in_last together with the MAX_LEN-th word: in_last wins
    for (int i = 0; i < MAX_LEN - 1; i++) send(4'(i + 2), 1'b0);
    send(4'h7, 1'b1);
    check("t3c_trunc_const", 32'(bus.out_trunc), 32'd0);
    check_frame("t3c");
    drain("t3c", 0);

    // 4: back-pressure for 5 cycles
    send(4'hC, 1'b0);
    send(4'h3, 1'b1);
    check("t4_sum_const", 32'(bus.out_sum), 32'hF);
    check_frame("t4");
    drain("t4", 5);

    // 5: idle gap inside a frame
    send(4'h2, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_gap_valid", 32'(bus.out_valid), 32'd0);
    send(4'h4, 1'b1);
    check("t5_sum_const", 32'(bus.out_sum), 32'h6);
    check_frame("t5");
    drain("t5", 0);

    // 6: reset mid-frame discards partial data
    send(4'h5, 1'b0);
    send(4'h7, 1'b0);
    rstn = 1'b0;
    frame_q.delete();
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_sum",   32'(bus.out_sum), 32'd0);
    check("t6_rst_len",   32'(bus.out_len), 32'd0);
    check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_post_ready", 32'(bus.in_ready), 32'd1);
    send(4'h9, 1'b1);
    check("t6_sum_const", 32'(bus.out_sum), 32'h9);
    check_frame("t6");
    drain("t6", 0);

    // Randomized frames, lengths beyond MAX_LEN exercise truncation
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, MAX_LEN + 3);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(4'($urandom), b == len - 1);
        if (pending) begin
          check_frame("rnd");
          drain("rnd", $urandom_range(0, 3));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
